jam_cost_eval: RTL

- Downstream stage of the JAM permutation generator. Each time the generator's next-permutation logic produces a job assignment, this block takes it and computes its total cost.
- For each worker it reads the external cost ROM through the W/J/Cost interface and sums the eight costs.
- It keeps a running minimum total cost and the number of permutations that reach that minimum.
- After the last permutation it presents MinCost/MatchCount with Valid.

---
 rtl/jam_pkg.sv | 26 ++
 rtl/jam_cost_eval_if.sv | 25 ++
 rtl/jam_min_track.sv | 27 ++
 rtl/jam_cost_eval.sv | 80 ++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// Shared types and constants for the JAM permutation cost evaluator.
package jam_pkg;
  localparam int N_WORK = 8;
  localparam int IDX_W  = 3;
  localparam int COST_W = 7;
  localparam int SUM_W  = 10;
  localparam int CNT_W  = 4;
  localparam int PERM_W = N_WORK * IDX_W;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORK - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    CMP,
    DONE
  } state_t;

  function automatic logic [IDX_W-1:0] perm_job(
    input logic [PERM_W-1:0] p,
    input logic [IDX_W-1:0]  w
  );
    return p[w*IDX_W +: IDX_W];
  endfunction
endpackage

// File: rtl/jam_cost_eval_if.sv
// Permutation handshake, cost ROM port and result bundle.
interface jam_cost_eval_if;
  import jam_pkg::*;

  logic [PERM_W-1:0] perm_in;
  logic              perm_valid;
  logic              perm_last;
  logic              perm_ready;
  logic [IDX_W-1:0]  W;
  logic [IDX_W-1:0]  J;
  logic [COST_W-1:0] Cost;
  logic [SUM_W-1:0]  MinCost;
  logic [CNT_W-1:0]  MatchCount;
  logic              Valid;

  modport slave (
    input  perm_in, perm_valid, perm_last, Cost,
    output perm_ready, W, J, MinCost, MatchCount, Valid
  );

  modport master (
    output perm_in, perm_valid, perm_last, Cost,
    input  perm_ready, W, J, MinCost, MatchCount, Valid
  );
endinterface

// File: rtl/jam_min_track.sv
// Running minimum of permutation totals and a saturating tie count.
module jam_min_track
  import jam_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [SUM_W-1:0] sum,
  output logic [SUM_W-1:0] min_cost,
  output logic [CNT_W-1:0] match_cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_cost  <= '1;
      match_cnt <= '0;
    end else if (en) begin
      if (sum < min_cost) begin
        min_cost  <= sum;
        match_cnt <= CNT_W'(1);
      end else if (sum == min_cost && match_cnt != '1) begin
        match_cnt <= match_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/jam_cost_eval.sv
// Sums ROM costs of each job assignment and tracks the minimum total.
module jam_cost_eval
  import jam_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  jam_cost_eval_if.slave  bus
);

  state_t            state;
  state_t            state_nx;
  logic [IDX_W-1:0]  idx;
  logic [PERM_W-1:0] perm;
  logic              last;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  cost_ext;
  logic              take;

  assign take     = bus.perm_valid && bus.perm_ready;
  assign cost_ext = SUM_W'(bus.Cost);

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (take) state_nx = FETCH;
      FETCH:   if (idx == LAST_IDX) state_nx = DRAIN;
      DRAIN:   state_nx = CMP;
      CMP:     state_nx = last ? DONE : IDLE;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // ROM data lags the address by one cycle, so slot idx adds cost idx-1
  always_ff @(posedge CLK) begin
    if (!RST) begin
      idx  <= '0;
      perm <= '0;
      last <= 1'b0;
      sum  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            perm <= bus.perm_in;
            last <= bus.perm_last;
            idx  <= '0;
            sum  <= '0;
          end
        end
        FETCH: begin
          if (idx != '0)       sum <= sum + cost_ext;
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        DRAIN:   sum <= sum + cost_ext;
        default: ;
      endcase
    end
  end

  assign bus.perm_ready = (state == IDLE);
  assign bus.W          = idx;
  assign bus.J          = perm_job(perm, idx);
  assign bus.Valid      = (state == DONE);

  jam_min_track u_min (
    .clk       (CLK),
    .rst_n     (RST),
    .en        (state == CMP),
    .sum       (sum),
    .min_cost  (bus.MinCost),
    .match_cnt (bus.MatchCount)
  );

endmodule
